// File: rtl/aes128_decrypt_iter_pkg.sv
// Shared types, constants and byte-level AES helpers for the iterative
// AES-128 decryption core.
//   state_t        : core FSM states (IDLE/EXPAND/ROUND/DONE)
//   NR/BLK_W/WORD_W: round count, block width, key word width
//   rcon, rot_word, get_word, sub_word, inv_sub_bytes, inv_shift_rows,
//   inv_mix_columns, generate_key4 : combinational round primitives
// Byte 0 of a block sits in bits [127:120]; bytes are column-major.
package aes128_decrypt_iter_pkg;

    localparam int NR     = 10;
    localparam int BLK_W  = 128;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} state_t;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [WORD_W-1:0] get_word(input logic [BLK_W-1:0] k, input int i);
        return k[BLK_W-1-WORD_W*i -: WORD_W];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (= a^2 * a^4 * ... * a^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq  = a;
        logic [7:0] res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [BLK_W-1:0] inv_sub_bytes(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        for (int i = 0; i < 16; i++) o[BLK_W-1-8*i -: 8] = inv_sbox(s[BLK_W-1-8*i -: 8]);
        return o;
    endfunction

    // Row r of column c takes the byte from column (c - r) mod 4.
    function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[BLK_W-1-8*(r+4*c) -: 8] = s[BLK_W-1-8*(r+4*((c+4-r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[BLK_W-1-32*c -: 8];
            a1 = s[BLK_W-9-32*c -: 8];
            a2 = s[BLK_W-17-32*c -: 8];
            a3 = s[BLK_W-25-32*c -: 8];
            o[BLK_W-1-32*c -: 8]  = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[BLK_W-9-32*c -: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[BLK_W-17-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[BLK_W-25-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Forward schedule step K(r-1) -> K(r).
    function automatic logic [BLK_W-1:0] generate_key4(input logic [BLK_W-1:0] k, input logic [3:0] r);
        logic [WORD_W-1:0] w0, w1, w2, w3;
        w0 = get_word(k, 0) ^ sub_word(rot_word(get_word(k, 3))) ^ {rcon(r), 24'h0};
        w1 = get_word(k, 1) ^ w0;
        w2 = get_word(k, 2) ^ w1;
        w3 = get_word(k, 3) ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes128_decrypt_iter_if.sv
// Block-in / plaintext-out bus of the AES-128 decryption core.
//   in_valid/in_ready/in_ct/in_key : ciphertext + key request
//   out_valid/out_ready/out_pt     : plaintext response
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; the source holds valid and data stable until that edge, and
// the sink may raise or drop ready freely.
// master = stimulus/consumer side, slave = the core.
interface aes128_decrypt_iter_if;
    logic                                     in_valid;
    logic                                     in_ready;
    logic [aes128_decrypt_iter_pkg::BLK_W-1:0] in_ct;
    logic [aes128_decrypt_iter_pkg::BLK_W-1:0] in_key;
    logic                                     out_valid;
    logic                                     out_ready;
    logic [aes128_decrypt_iter_pkg::BLK_W-1:0] out_pt;

    modport master (output in_valid, in_ct, in_key, out_ready,
                    input  in_ready, out_valid, out_pt);
    modport slave  (input  in_valid, in_ct, in_key, out_ready,
                    output in_ready, out_valid, out_pt);
endinterface

// File: rtl/aes128_decrypt_iter_inv_key_step.sv
// Reverse key schedule step: K(r) -> K(r-1), purely combinational.
//   rk  : round key K(r)
//   rnd : r (1..10), selects Rcon(r)
//   kp  : round key K(r-1)
module aes128_decrypt_iter_inv_key_step
    import aes128_decrypt_iter_pkg::*;
(
    input  logic [BLK_W-1:0] rk,
    input  logic [3:0]       rnd,
    output logic [BLK_W-1:0] kp
);
    logic [WORD_W-1:0] w0, w1, w2, w3;

    // Undo the forward chaining from the top word down; w3 of K(r-1) must be
    // recovered before it can feed SubWord for w0.
    always_comb begin
        w3 = get_word(rk, 3) ^ get_word(rk, 2);
        w2 = get_word(rk, 2) ^ get_word(rk, 1);
        w1 = get_word(rk, 1) ^ get_word(rk, 0);
        w0 = get_word(rk, 0) ^ sub_word(rot_word(w3)) ^ {rcon(rnd), 24'h0};
        kp = {w0, w1, w2, w3};
    end
endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryption: one round per clock, round keys derived on
// the fly (forward to K10, then backwards), so no key schedule is stored.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : aes128_decrypt_iter_if.slave (request and response handshakes)
//   dbg_state : current FSM state
// Optional build macro AES_DEC_KEY_CACHE_EN: remembers the last key and its
// K10 so a repeat key skips the forward expansion (10-cycle latency).
module aes128_decrypt_iter
    import aes128_decrypt_iter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    aes128_decrypt_iter_if.slave  bus,
    output state_t                dbg_state
);
    state_t           state, state_nxt;
    logic [BLK_W-1:0] st, rk;
    logic [3:0]       rnd;
    logic [BLK_W-1:0] k_fwd, kp, t;
    logic             cache_hit;

    localparam logic [3:0] LAST = 4'(NR);

    aes128_decrypt_iter_inv_key_step u_inv_key_step (.rk(rk), .rnd(rnd), .kp(kp));

    always_comb begin
        k_fwd = generate_key4(rk, rnd);
        t     = inv_sub_bytes(inv_shift_rows(st)) ^ kp;
    end

`ifdef AES_DEC_KEY_CACHE_EN
    logic [BLK_W-1:0] cache_key, cache_k10;
    logic             cache_vld;

    assign cache_hit = cache_vld && (bus.in_key == cache_key);

    // The key is captured on a missing accept rather than at the end of
    // EXPAND: no accept or lookup can occur in between, and rk no longer
    // holds K0 by then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_key <= '0;
            cache_k10 <= '0;
            cache_vld <= 1'b0;
        end else begin
            if (state == IDLE && bus.in_valid && !cache_hit) cache_key <= bus.in_key;
            if (state == EXPAND && rnd == LAST) begin
                cache_k10 <= k_fwd;
                cache_vld <= 1'b1;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = cache_hit ? ROUND : EXPAND;
            EXPAND:  if (rnd == LAST)  state_nxt = ROUND;
            ROUND:   if (rnd == 4'd1)  state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= '0;
            rk  <= '0;
            rnd <= 4'd0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
`ifdef AES_DEC_KEY_CACHE_EN
                    if (cache_hit) begin
                        st  <= bus.in_ct ^ cache_k10;
                        rk  <= cache_k10;
                        rnd <= LAST;
                    end else begin
                        st  <= bus.in_ct;
                        rk  <= bus.in_key;
                        rnd <= 4'd1;
                    end
`else
                    st  <= bus.in_ct;
                    rk  <= bus.in_key;
                    rnd <= 4'd1;
`endif
                end
                EXPAND: begin
                    rk <= k_fwd;
                    // Last forward step also applies the initial AddRoundKey
                    // and leaves rnd at 10 for the first inverse round.
                    if (rnd == LAST) st  <= st ^ k_fwd;
                    else             rnd <= rnd + 4'd1;
                end
                ROUND: begin
                    st  <= (rnd == 4'd1) ? t : inv_mix_columns(t);
                    rk  <= kp;
                    rnd <= rnd - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_pt    = (state == DONE) ? st : '0;
    assign dbg_state     = state;
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
module tb_aes128_decrypt_iter;
    import aes128_decrypt_iter_pkg::*;

`ifdef AES_DEC_KEY_CACHE_EN
    localparam int HIT_LAT = 10;
`else
    localparam int HIT_LAT = 20;
`endif

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     checks = 0;
    int     errors = 0;
    logic [127:0] exp_q[$];

    aes128_decrypt_iter_if bus();

    aes128_decrypt_iter dut (.clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model: forward AES-128 ----------------
    logic [7:0] sbox_t [256];

    // S-box built by walking the multiplicative group with generator 3.
    function automatic void build_sbox();
        logic [7:0] p = 8'h01;
        logic [7:0] q = 8'h01;
        logic [7:0] x;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic void aes_enc(input logic [127:0] pt, input logic [127:0] key,
                                    output logic [127:0] ct, output logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] tw;
        logic [7:0]  s [16];
        logic [7:0]  m [16];
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {sbox_t[tw[23:16]], sbox_t[tw[15:8]], sbox_t[tw[7:0]], sbox_t[tw[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    m[r+4*c] = sbox_t[s[r+4*((c+r)%4)]];
            for (int c = 0; c < 4; c++) begin
                if (rd < 10) begin
                    s[4*c]   = xt(m[4*c]) ^ xt(m[4*c+1]) ^ m[4*c+1] ^ m[4*c+2] ^ m[4*c+3];
                    s[4*c+1] = m[4*c] ^ xt(m[4*c+1]) ^ xt(m[4*c+2]) ^ m[4*c+2] ^ m[4*c+3];
                    s[4*c+2] = m[4*c] ^ m[4*c+1] ^ xt(m[4*c+2]) ^ xt(m[4*c+3]) ^ m[4*c+3];
                    s[4*c+3] = xt(m[4*c]) ^ m[4*c] ^ m[4*c+1] ^ m[4*c+2] ^ xt(m[4*c+3]);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = m[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        k10 = {w[40], w[41], w[42], w[43]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one block, start/end at #1 after posedge -----
    task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] key,
                             input logic [127:0] exp_pt, input logic [127:0] exp_k10,
                             input int exp_lat, input int hold);
        int   lat = 0;
        logic seen = 1'b0;
        logic busy_bad = 1'b0;
        logic hold_bad = 1'b0;
        logic [127:0] held;
        check({tag, "_idle_ready"}, {127'd0, bus.in_ready}, 128'd1);
        bus.in_valid  = 1'b1;
        bus.in_ct     = ct;
        bus.in_key    = key;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        while (!seen && lat < 64) begin
            // inputs only matter on the accept edge; scramble them meanwhile
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_ct    = rand128();
            bus.in_key   = rand128();
            @(posedge clk); #1;
            lat++;
            if (lat == 10 && exp_lat == 20) check({tag, "_k10"}, dut.rk, exp_k10);
            if (bus.out_valid) seen = 1'b1;
            else if (bus.in_ready) busy_bad = 1'b1;
        end
        bus.in_valid = 1'b0;
        check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        check({tag, "_busy_ready"}, {127'd0, busy_bad}, 128'd0);
        check({tag, "_pt"}, bus.out_pt, exp_pt);
        held = bus.out_pt;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (bus.out_pt !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) hold_bad = 1'b1;
        end
        if (hold > 0) check({tag, "_hold"}, {127'd0, hold_bad}, 128'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_after_valid"}, {127'd0, bus.out_valid}, 128'd0);
        check({tag, "_after_ready"}, {127'd0, bus.in_ready}, 128'd1);
    endtask

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    initial begin
        logic [127:0] pt, key, ct, k10;
        logic [127:0] ct_a [4];
        logic [127:0] key_a [4];
        logic         late_out;
        int sent, got, cyc, last_done;

        build_sbox();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_ct = '0;
        bus.in_key = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
        check("rst_out_pt", bus.out_pt, 128'd0);
        check("rst_state", 128'(dbg_state), 128'(IDLE));
        check("rst_rnd", 128'(dut.rnd), 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", {127'd0, bus.in_ready}, 128'd1);

        // FIPS vectors and cache behaviour
        run_block("c1", C1_CT, C1_KEY, C1_PT, C1_K10, 20, 0);
        run_block("appb", B_CT, B_KEY, B_PT, B_K10, 20, 0);
        run_block("c1_miss", C1_CT, C1_KEY, C1_PT, C1_K10, 20, 0);
        run_block("c1_repeat", C1_CT, C1_KEY, C1_PT, C1_K10, HIT_LAT, 0);
        run_block("appb_replace", B_CT, B_KEY, B_PT, B_K10, 20, 0);
        run_block("c1_replace", C1_CT, C1_KEY, C1_PT, C1_K10, 20, 0);

        // reset at E15 (mid-ROUND)
        bus.in_valid = 1'b1;
        bus.in_ct = C1_CT;
        bus.in_key = C1_KEY;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("abort_valid", {127'd0, bus.out_valid}, 128'd0);
        check("abort_state", 128'(dbg_state), 128'(IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", {127'd0, bus.in_ready}, 128'd1);
        late_out = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.out_valid) late_out = 1'b1;
        end
        check("abort_no_output", {127'd0, late_out}, 128'd0);
        run_block("c1_after_rst", C1_CT, C1_KEY, C1_PT, C1_K10, 20, 0);

        // random keys/plaintexts, including a repeated key and backpressure
        for (int n = 0; n < 3; n++) begin
            pt = rand128();
            key = rand128();
            aes_enc(pt, key, ct, k10);
            run_block($sformatf("rnd%0d", n), ct, key, pt, k10, 20, (n == 1) ? 7 : 0);
            pt = rand128();
            aes_enc(pt, key, ct, k10);
            run_block($sformatf("rnd%0d_same_key", n), ct, key, pt, k10, HIT_LAT, 0);
        end

        // back-to-back: in_valid held, out_ready tied high
        for (int n = 0; n < 4; n++) begin
            pt = rand128();
            key_a[n] = rand128();
            aes_enc(pt, key_a[n], ct_a[n], k10);
            exp_q.push_back(pt);
        end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        sent = 0;
        got = 0;
        cyc = 0;
        last_done = -1;
        while (got < 4 && cyc < 300) begin
            if (bus.in_ready) begin
                if (sent < 4) begin
                    bus.in_ct = ct_a[sent];
                    bus.in_key = key_a[sent];
                    sent++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (bus.out_valid) begin
                check($sformatf("b2b_pt%0d", got), bus.out_pt, exp_q.pop_front());
                if (last_done >= 0) check($sformatf("b2b_gap%0d", got), 128'(cyc - last_done), 128'd22);
                last_done = cyc;
                got++;
            end
        end
        bus.in_valid = 1'b0;
        check("b2b_count", 128'(got), 128'd4);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
